// File: rtl/dmem_arbiter.sv
// Two-master data-memory arbiter (round-robin or fixed m0 priority); partial-byte writes use read-modify-write.
// Ack 2 cycles after req is sampled in IDLE (3 for partial writes); req is held by the master until its ack.
module dmem_arbiter #(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_be,
  output logic        m0_ack,
  output logic [31:0] m0_rdata,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_be,
  output logic        m1_ack,
  output logic [31:0] m1_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_we,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, ACCESS, MERGE, RESP} state_t;

  state_t      state, state_nxt;
  logic        rr, rr_d;
  logic        win, win_d;
  logic        lat_we, lat_we_d;
  logic [3:0]  lat_be, lat_be_d;
  logic [31:0] lat_wdata, lat_wdata_d;
  logic [31:0] addr_d, wdata_d, rdata0_d, rdata1_d;
  logic        we_d, mem_we_q, ack0_d, ack1_d;
  logic        sel, sel_we, partial;
  logic [31:0] sel_addr, sel_wdata, merged;
  logic [3:0]  sel_be;

  // Winner select: sel = 1 means m1; a lone requester wins regardless of rr.
  always_comb begin
    if (m0_req && m1_req) sel = PRIO_FIXED ? 1'b0 : rr;
    else                  sel = m1_req;
    sel_we    = sel ? m1_we    : m0_we;
    sel_addr  = sel ? m1_addr  : m0_addr;
    sel_wdata = sel ? m1_wdata : m0_wdata;
    sel_be    = sel ? m1_be    : m0_be;
    partial   = lat_we && (lat_be != 4'h0) && (lat_be != 4'hF);
    merged    = '0;
    for (int i = 0; i < 4; i++)
      merged[8*i +: 8] = lat_be[i] ? lat_wdata[8*i +: 8] : mem_rdata[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (m0_req || m1_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = partial ? MERGE : RESP;
      MERGE:   state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered outputs, aligned to the state being entered.
  always_comb begin
    rr_d        = rr;
    win_d       = win;
    lat_we_d    = lat_we;
    lat_be_d    = lat_be;
    lat_wdata_d = lat_wdata;
    addr_d      = mem_addr;
    wdata_d     = mem_wdata;
    we_d        = 1'b0;
    rdata0_d    = m0_rdata;
    rdata1_d    = m1_rdata;
    case (state)
      IDLE: begin
        if (m0_req || m1_req) begin
          win_d       = sel;
          rr_d        = ~sel;
          lat_we_d    = sel_we;
          lat_be_d    = sel_be;
          lat_wdata_d = sel_wdata;
          addr_d      = {sel_addr[31:2], 2'b00};
          wdata_d     = sel_wdata;
          we_d        = sel_we && (sel_be == 4'hF);
        end
      end
      ACCESS: begin
        if (!lat_we) begin
          if (win) rdata1_d = mem_rdata;
          else     rdata0_d = mem_rdata;
        end else if (partial) begin
          we_d    = 1'b1;
          wdata_d = merged;
        end
      end
      default: ;
    endcase
    ack0_d = (state_nxt == RESP) && !win;
    ack1_d = (state_nxt == RESP) &&  win;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr        <= 1'b0;
      win       <= 1'b0;
      lat_we    <= 1'b0;
      lat_be    <= 4'h0;
      lat_wdata <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_we_q  <= 1'b0;
      m0_ack    <= 1'b0;
      m1_ack    <= 1'b0;
      m0_rdata  <= '0;
      m1_rdata  <= '0;
    end else begin
      rr        <= rr_d;
      win       <= win_d;
      lat_we    <= lat_we_d;
      lat_be    <= lat_be_d;
      lat_wdata <= lat_wdata_d;
      mem_addr  <= addr_d;
      mem_wdata <= wdata_d;
      mem_we_q  <= we_d;
      m0_ack    <= ack0_d;
      m1_ack    <= ack1_d;
      m0_rdata  <= rdata0_d;
      m1_rdata  <= rdata1_d;
    end
  end

  // Reset asserted during a write cycle must keep that write out of memory at the same edge.
  assign mem_we = mem_we_q & rst_n;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Bench for dmem_arbiter: transaction-level memory/rdata model, random single-master traffic,
// directed contention for both priority modes, and reset abort during a merge write.
module tb_dmem_arbiter;

  logic        clk, rst_n;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [3:0]  m0_be, m1_be;
  logic        m0_ack, m1_ack, mem_we;
  logic [31:0] m0_rdata, m1_rdata, mem_addr, mem_wdata, mem_rdata;
  logic        fx_m0_ack, fx_m1_ack, fx_mem_we;
  logic [31:0] fx_m0_rdata, fx_m1_rdata, fx_mem_addr, fx_mem_wdata, fx_mem_rdata;

  logic [31:0] mem [64];
  logic [31:0] fx_mem [64];
  logic        bd_we;
  logic [5:0]  bd_idx;
  logic [31:0] bd_dat;

  logic [31:0] ref_mem [64];
  logic [31:0] last_rd [2];
  int vectors, miscompares;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  dmem_arbiter #(.PRIO_FIXED(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_ack(m0_ack), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_ack(m1_ack), .m1_rdata(m1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.PRIO_FIXED(1'b1)) dut_fx (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
    .m0_ack(fx_m0_ack), .m0_rdata(fx_m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
    .m1_ack(fx_m1_ack), .m1_rdata(fx_m1_rdata),
    .mem_addr(fx_mem_addr), .mem_wdata(fx_mem_wdata), .mem_we(fx_mem_we), .mem_rdata(fx_mem_rdata)
  );

  assign mem_rdata    = mem[mem_addr[7:2]];
  assign fx_mem_rdata = fx_mem[fx_mem_addr[7:2]];

  always @(posedge clk) begin
    if (bd_we)       mem[bd_idx] <= bd_dat;
    else if (mem_we) mem[mem_addr[7:2]] <= mem_wdata;
  end

  always @(posedge clk) if (fx_mem_we) fx_mem[fx_mem_addr[7:2]] <= fx_mem_wdata;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int m, input logic req, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be);
    if (m == 0) begin
      m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_be = be;
    end else begin
      m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_be = be;
    end
  endtask

  // One isolated transaction; expected values come from the word-level memory model.
  task automatic txn(input int m, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input bit drop_early);
    logic [5:0]  idx;
    logic [31:0] mask, exp_word;
    int lat, we_cnt, exp_lat;
    bit seen;
    idx = addr[7:2];
    for (int i = 0; i < 4; i++) mask[8*i +: 8] = {8{be[i]}};
    exp_word = we ? ((wdata & mask) | (ref_mem[idx] & ~mask)) : ref_mem[idx];
    exp_lat  = (we && be != 4'h0 && be != 4'hF) ? 3 : 2;
    @(negedge clk);
    drive(m, 1'b1, we, addr, wdata, be);
    lat = 0; we_cnt = 0; seen = 0;
    while (!seen && lat < 8) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk("mem_addr", mem_addr, {addr[31:2], 2'b00});
        if (drop_early) drive(m, 1'b0, 1'($urandom), $urandom, $urandom, 4'($urandom));
      end
      if (mem_we) begin
        we_cnt++;
        chk("mem_wdata", mem_wdata, exp_word);
      end
      if (m0_ack || m1_ack) begin
        seen = 1;
        chk("ack_owner", 32'({m1_ack, m0_ack}), (m == 0) ? 32'd1 : 32'd2);
        chk("latency", lat, exp_lat);
        if (!we) last_rd[m] = exp_word;
        chk("rdata_own", (m == 0) ? m0_rdata : m1_rdata, last_rd[m]);
        chk("rdata_other", (m == 0) ? m1_rdata : m0_rdata, last_rd[1-m]);
        drive(m, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      end
    end
    chk("ack_seen", 32'(seen), 32'd1);
    chk("we_pulses", we_cnt, (we && be != 4'h0) ? 1 : 0);
    if (we) ref_mem[idx] = exp_word;
    chk("mem_word", mem[idx], ref_mem[idx]);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m0_ack"}, 32'(m0_ack), 32'd0);
    chk({tag, "_m1_ack"}, 32'(m1_ack), 32'd0);
    chk({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    chk({tag, "_mem_addr"}, mem_addr, 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_m0_rdata"}, m0_rdata, 32'd0);
    chk({tag, "_m1_rdata"}, m1_rdata, 32'd0);
  endtask

  initial begin
    int n_ack, cyc, fx0, fx1;
    logic [3:0] be;
    vectors = 0; miscompares = 0;
    rst_n = 1'b0; bd_we = 1'b0; bd_idx = '0; bd_dat = '0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    last_rd[0] = '0; last_rd[1] = '0;

    // Preload memory through a backdoor port while held in reset.
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      bd_we = 1'b1; bd_idx = 6'(i);
      bd_dat = (i == 4) ? 32'hDEADBEEF : (i == 5) ? 32'h11223344 : $urandom;
      ref_mem[i] = bd_dat;
    end
    @(negedge clk);
    bd_we = 1'b0;
    @(negedge clk);
    chk_reset_outputs("rst");

    // Both masters held from the first cycle out of reset.
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b0, 32'h20, 32'h0, 4'h0);
    drive(1, 1'b1, 1'b0, 32'h24, 32'h0, 4'h0);
    n_ack = 0; cyc = 0; fx0 = 0; fx1 = 0;
    while (n_ack < 4 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      fx0 += int'(fx_m0_ack);
      fx1 += int'(fx_m1_ack);
      if (m0_ack || m1_ack) begin
        if (n_ack == 0) chk("first_ack_lat", cyc, 2);
        chk("rr_order", 32'({m1_ack, m0_ack}), (n_ack % 2 == 0) ? 32'd1 : 32'd2);
        chk("rr_rdata", m0_ack ? m0_rdata : m1_rdata, m0_ack ? ref_mem[8] : ref_mem[9]);
        n_ack++;
      end
    end
    chk("rr_ack_count", n_ack, 4);
    chk("fx_m0_acks", fx0, 4);
    chk("fx_m1_acks", fx1, 0);
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    last_rd[0] = ref_mem[8];
    last_rd[1] = ref_mem[9];

    // Directed: unaligned read, byte-2 merge write, empty-byte-enable write.
    txn(0, 1'b0, 32'h0000_0013, 32'h0, 4'hF, 1'b0);
    txn(1, 1'b1, 32'h0000_0014, 32'h00AB_0000, 4'b0100, 1'b0);
    txn(0, 1'b1, 32'h0000_0030, 32'hCAFE_F00D, 4'b0000, 1'b0);

    // Random single-master traffic, sometimes abandoning req right after grant.
    for (int t = 0; t < 40; t++) begin
      be = ($urandom_range(0, 2) == 0) ? 4'hF : 4'($urandom_range(0, 15));
      txn($urandom_range(0, 1), 1'($urandom), 32'($urandom_range(0, 255)), $urandom, be,
          $urandom_range(0, 3) == 0);
    end

    // Reset while the merge write is on the memory port.
    @(negedge clk);
    drive(1, 1'b1, 1'b1, 32'h0000_0028, 32'h5555_AAAA, 4'b0011);
    @(negedge clk);
    @(negedge clk);
    chk("merge_we_before_rst", 32'(mem_we), 32'd1);
    rst_n = 1'b0;
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    #1;
    chk("merge_we_in_rst", 32'(mem_we), 32'd0);
    @(negedge clk);
    chk("merge_aborted_word", mem[10], ref_mem[10]);
    chk_reset_outputs("abort");
    last_rd[0] = '0; last_rd[1] = '0;
    @(negedge clk);
    rst_n = 1'b1;
    txn(1, 1'b0, 32'h0000_0028, 32'h0, 4'hF, 1'b0);
    txn(0, 1'b1, 32'h0000_0028, 32'h1234_5678, 4'b1001, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
